// File: rtl/zii_pkg.sv
// Shared definitions for the Zorro II fast-RAM controller: cycle state
// encoding, RAM window size constants and the window decode helper.
package zii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MISS    = 3'd1,
    ST_SELECT  = 3'd2,
    ST_STROBE  = 3'd3,
    ST_ACK     = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  // Number of 2 MB chunks in the RAM window for each jumper setting.
  localparam int unsigned RAM_CHUNKS_8M = 4;
  localparam int unsigned RAM_CHUNKS_4M = 2;

  // Chunk offset of an address relative to the assigned base, 3-bit wrap.
  function automatic logic [2:0] ram_offset(input logic [2:0] a_high,
                                            input logic [2:0] base);
    return a_high - base;
  endfunction

  // Board hit: base is valid and the offset falls inside the window.
  function automatic logic ram_hit(input logic [2:0] offset,
                                   input logic       configured_n,
                                   input logic       jp4);
    logic [3:0] limit;
    limit = jp4 ? 4'(RAM_CHUNKS_8M) : 4'(RAM_CHUNKS_4M);
    return !configured_n && ({1'b0, offset} < limit);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bus strobe.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Shift the raw input through two flops; reset parks both at RESET_VAL.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/zii_ram_ctrl.sv
// Zorro II fast-RAM access controller. Decodes CPU cycles against the
// AutoConfig-assigned window and sequences SRAM strobes, SLAVE_n and DTACK_n
// on C7M. DBG_STATE exposes the cycle state for observation.
//
// Handshake: the CPU holds AS_CPU_n low for the whole cycle; the board claims
// it with SLAVE_n, acknowledges with DTACK_n low, and the cycle ends only when
// the CPU negates AS_CPU_n, after which DTACK_n is driven high for one cycle
// before its output enable is released.
module zii_ram_ctrl
  import zii_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       C7M,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW_n,
  input  logic [2:0] A_HIGH,
  input  logic [2:0] BASE_RAM,
  input  logic       RAM_CONFIGURED_n,
  input  logic       JP4,
  output logic [1:0] RAM_BANK,
  output logic       RAM_CS_n,
  output logic       RAM_OE_n,
  output logic       RAM_UWE_n,
  output logic       RAM_LWE_n,
  output logic       SLAVE_n,
  output logic       DTACK_n,
  output logic       DTACK_OE,
  output logic [2:0] DBG_STATE
);

  logic       w_as_n;
  logic       w_uds_n;
  logic       w_lds_n;
  logic [2:0] w_offset;
  logic       w_hit;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_bank;
  logic       r_rw_n;
  logic [2:0] r_wait_cnt;
  logic       r_uwe_n;
  logic       r_lwe_n;
  logic       w_slave_n;
  logic       w_cs_n;
  logic       w_oe_n;
  logic       w_uwe_n;
  logic       w_lwe_n;
  logic       w_dtack_n;
  logic       w_dtack_oe;

  sync2 #(.RESET_VAL(1'b1)) u_sync_as (
    .i_clk(C7M), .i_rst(RESET), .i_d(AS_CPU_n), .o_q(w_as_n)
  );
  sync2 #(.RESET_VAL(1'b1)) u_sync_uds (
    .i_clk(C7M), .i_rst(RESET), .i_d(UDS_n), .o_q(w_uds_n)
  );
  sync2 #(.RESET_VAL(1'b1)) u_sync_lds (
    .i_clk(C7M), .i_rst(RESET), .i_d(LDS_n), .o_q(w_lds_n)
  );

  // Address is only meaningful while AS is low; it is consumed in IDLE.
  assign w_offset = ram_offset(A_HIGH, BASE_RAM);
  assign w_hit    = ram_hit(w_offset, RAM_CONFIGURED_n, JP4);

  // Cycle state register.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-cycle context: bank and direction captured at decode, wait counter,
  // and the last write strobes seen in STROBE so ACK holds them steady even
  // if the data strobes rise before AS does.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      r_bank     <= 2'b00;
      r_rw_n     <= 1'b1;
      r_wait_cnt <= 3'd0;
      r_uwe_n    <= 1'b1;
      r_lwe_n    <= 1'b1;
    end else begin
      if (r_state == ST_IDLE && !w_as_n && w_hit) begin
        r_bank <= w_offset[1:0];
        r_rw_n <= RW_n;
      end
      if (r_state == ST_SELECT) begin
        r_wait_cnt <= 3'(WAIT_STATES);
      end else if (r_state == ST_STROBE && r_wait_cnt != 3'd0) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (r_state == ST_STROBE) begin
        r_uwe_n <= w_uds_n;
        r_lwe_n <= w_lds_n;
      end
    end
  end

  // Next-state and strobe decode; every output idles unless a state drives it.
  always_comb begin
    w_state_nxt = r_state;
    w_slave_n   = 1'b1;
    w_cs_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_uwe_n     = 1'b1;
    w_lwe_n     = 1'b1;
    w_dtack_n   = 1'b1;
    w_dtack_oe  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_as_n) begin
          w_state_nxt = w_hit ? ST_SELECT : ST_MISS;
        end
      end
      ST_MISS: begin
        if (w_as_n) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SELECT: begin
        w_slave_n  = 1'b0;
        w_cs_n     = 1'b0;
        w_dtack_oe = 1'b1;
        if (w_as_n) begin
          w_state_nxt = ST_RECOVER;
        end else if (!w_uds_n || !w_lds_n) begin
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        w_slave_n  = 1'b0;
        w_cs_n     = 1'b0;
        w_dtack_oe = 1'b1;
        if (r_rw_n) begin
          w_oe_n = 1'b0;
        end else begin
          w_uwe_n = w_uds_n;
          w_lwe_n = w_lds_n;
        end
        if (w_as_n) begin
          w_state_nxt = ST_RECOVER;
        end else if (r_wait_cnt == 3'd0) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_slave_n  = 1'b0;
        w_cs_n     = 1'b0;
        w_dtack_oe = 1'b1;
        w_dtack_n  = 1'b0;
        if (r_rw_n) begin
          w_oe_n = 1'b0;
        end else begin
          w_uwe_n = r_uwe_n;
          w_lwe_n = r_lwe_n;
        end
        if (w_as_n) begin
          w_state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        // Actively drive DTACK_n high for one cycle before releasing it.
        w_dtack_oe  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign RAM_BANK  = r_bank;
  assign SLAVE_n   = w_slave_n;
  assign RAM_CS_n  = w_cs_n;
  assign RAM_OE_n  = w_oe_n;
  assign RAM_UWE_n = w_uwe_n;
  assign RAM_LWE_n = w_lwe_n;
  assign DTACK_n   = w_dtack_n;
  assign DTACK_OE  = w_dtack_oe;
  assign DBG_STATE = r_state;

endmodule

// File: doc/zii_ram_ctrl.md
# zii_ram_ctrl

Zorro II fast-RAM access controller, directly downstream of the AutoConfig stage. It consumes the assigned RAM base (`BASE_RAM[7:5]`) and the RAM configured flag, and decodes CPU bus cycles against the 4/8 MB window. It runs a C7M-synchronous cycle state machine that drives SRAM strobes, `SLAVE_n` and `DTACK_n`. It does not touch data; the data path is a transparent buffer enabled by its strobes.

## Interface
- `WAIT_STATES`, default 1: extra C7M cycles inserted between strobe assertion and DTACK (0–7).
- `C7M`  in  1  7 MHz bus clock; all logic rises on it.
- `RESET`  in  1  synchronous, active-high reset.
- `AS_CPU_n`  in  1  address strobe, asynchronous to C7M.
- `UDS_n`, `LDS_n`  in  1 each  data strobes, asynchronous.
- `RW_n`  in  1  1 = read.
- `A_HIGH`  in  3  address bits [23:21].
- `BASE_RAM`  in  3  assigned base bits [7:5] from AutoConfig.
- `RAM_CONFIGURED_n`  in  1  0 = base valid.
- `JP4`  in  1  1 = 8 MB, 0 = 4 MB.
- `RAM_BANK`  out  2  2 MB chunk index (offset[1:0]).
- `RAM_CS_n`, `RAM_OE_n`, `RAM_UWE_n`, `RAM_LWE_n`  out  1 each  SRAM strobes.
- `SLAVE_n`  out  1  board-selected indication to the bus.
- `DTACK_n`, `DTACK_OE`  out  1 each  acknowledge value and its tristate enable.

## Operation
- `AS_CPU_n`, `UDS_n` and `LDS_n` each pass through a 2-flop synchronizer. `A_HIGH` and `RW_n` are sampled on the C7M edge where synchronized AS is first seen low.
- Decode:
  - offset = (`A_HIGH` − `BASE_RAM`) mod 8, 3-bit wrap arithmetic.
  - hit = !`RAM_CONFIGURED_n` && offset < (`JP4` ? 4 : 2).
- States:
  - IDLE: synchronized AS low and hit → SELECT; synchronized AS low and miss → MISS.
  - MISS: stays until synchronized AS high → IDLE. All outputs idle.
  - SELECT: `SLAVE_n`=0, `RAM_CS_n`=0, `DTACK_OE`=1 (`DTACK_n`=1). Load wait counter with `WAIT_STATES`. Proceeds on the first cycle with any synchronized DS low → STROBE.
  - STROBE:
    - Reads: `RAM_OE_n`=0.
    - Writes: `RAM_UWE_n`/`RAM_LWE_n` = synchronized `UDS_n`/`LDS_n`.
    - Counter decrements each cycle; at 0 → ACK.
  - ACK: `DTACK_n`=0 and strobes held. Stays until synchronized AS high → RECOVER.
  - RECOVER: all strobes negated, `DTACK_n`=1, `DTACK_OE` still 1 for one cycle → IDLE. This drives DTACK high before release.
- `RAM_BANK` is registered with the decode and held constant from SELECT through RECOVER.
- AS negating in SELECT or STROBE, i.e. an aborted cycle, goes straight to RECOVER.
- `RAM_CONFIGURED_n` rising mid-cycle does not abort; the new value applies at the next IDLE decode.

## Timing
- Reset values: `SLAVE_n`, `RAM_CS_n`, `RAM_OE_n`, `RAM_UWE_n`, `RAM_LWE_n` and `DTACK_n` are all 1. `DTACK_OE`=0, `RAM_BANK`=0, state IDLE, synchronizers all 1.
- RESET in any state returns everything to reset values on the next C7M edge.
- Raw AS low → SELECT outputs: 3 edges (2 sync + 1 decode).
- Synchronized DS low → strobe: +1 edge.
- Strobe → `DTACK_n` low: `WAIT_STATES`+1 edges.
- Raw AS high → strobes off: 3 edges. `DTACK_OE` drops 1 edge later.
- Back-to-back cycles: IDLE accepts a new AS on the edge after RECOVER. There is no other minimum gap.

## Structure
- Shared package `zii_pkg` holds:
  - the state encoding (IDLE, MISS, SELECT, STROBE, ACK, RECOVER);
  - the size constants RAM_CHUNKS_8M=4 and RAM_CHUNKS_4M=2.
- Sub-module `sync2` is a 2-flop synchronizer, instantiated three times (AS, UDS, LDS) with reset value 1.

## Test plan
- Configure base=3'b001, `JP4`=1, read at A[23:21]=3'b100 → SLAVE 3 edges after AS; `RAM_OE_n` low; `RAM_BANK`=2'b11; `DTACK_n` low `WAIT_STATES`+1 edges after DS.
- Same base, `JP4`=0, access at 3'b011 → MISS. `SLAVE_n`, `DTACK_OE` and all strobes stay inactive.
- Base=3'b111, `JP4`=1, access at 3'b001 → wrap offset 2, hit, `RAM_BANK`=2'b10.
- Byte write with `UDS_n`=0, `LDS_n`=1 → only `RAM_UWE_n` low. Then AS high → RECOVER: DTACK driven high for 1 cycle, then `DTACK_OE`=0.
- AS negated during STROBE with `WAIT_STATES`=3 → no DTACK low; strobes off next edge; back to IDLE after RECOVER.
- RESET asserted in ACK → all outputs at reset values after one edge. `RAM_CONFIGURED_n`=1 → every access goes to MISS.
